// File: rtl/add_serial_arb.sv
// Two-requester round-robin arbiter in front of one shared bit-serial adder.
// Ports: clk, rst (sync, active-high); req0/req1 level requests; a0/b0/a1/b1
// operands; gnt0/gnt1 and done0/done1 pulses; out/cout result; busy.
module add_serial_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  logic sum_bit;
  logic maj_bit;
  logic pick1;

  assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj_bit = (a_q[0] & b_q[0]) |
                   (a_q[0] & carry_q) |
                   (b_q[0] & carry_q);

  // last_q is the requester served most recently; a tie
  // goes to the other one.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          carry_d = 1'b0;
          cnt_d   = '0;
          owner_d = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          state_d = ADD;
        end
      end
      ADD: begin
        out_d   = {sum_bit, out_q[WIDTH-1:1]};
        carry_d = maj_bit;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = maj_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        // done is registered: it pulses in the cycle after DONE,
        // keeping it apart from any grant pulse.
        done0_d = ~owner_q;
        done1_d = owner_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign out   = out_q;
  assign cout  = cout_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_add_serial_arb.sv
// Scoreboard bench for add_serial_arb: expected results queued at
// stimulus time, checked against grant order and done pulses.
module tb_add_serial_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = '0;
  logic [7:0] b0 = '0;
  logic [7:0] a1 = '0;
  logic [7:0] b1 = '0;
  logic       gnt0, gnt1, done0, done1, cout, busy;
  logic [7:0] out;

  add_serial_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .out(out), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       owner;
    logic [7:0] sum;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   prev_done = 0;
  bit   gap_en = 0;
  bit   have_prev = 0;
  int   gnt1_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic o, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return '{owner: o, sum: s[7:0], c: s[8]};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 || gnt1 || done0 || done1)
        check("excl", {29'd0, gnt0 & gnt1, done0 & done1,
                       (gnt0 | gnt1) & (done0 | done1)}, 0);
      if (gnt1) gnt1_cnt++;
      if (gnt0 || gnt1) begin
        gnt_cyc = cyc;
        check("busy_gnt", busy, 1);
        if (exp_q.size() > 0) check("gnt_owner", gnt1, exp_q[0].owner);
        else check("gnt_unexp", 1, 0);
      end
      if (done0 || done1) begin
        check("busy_done", busy, 0);
        check("latency", cyc - gnt_cyc, 9);
        if (gap_en && have_prev) check("done_gap", cyc - prev_done, 10);
        prev_done = cyc;
        have_prev = 1;
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_owner", done1, e.owner);
          check("out", out, e.sum);
          check("cout", cout, e.c);
        end else begin
          check("done_unexp", 1, 0);
        end
      end
    end
  end

  task automatic wait_gnt();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) ok = 1;
    end
    check("gnt_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !done0 && !done1) ok = 1;
    end
    check("idle_timeout", ok, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tie(logic [7:0] x0, logic [7:0] y0,
                     logic [7:0] x1, logic [7:0] y1);
    exp_q.push_back(mk(1'b0, x0, y0));
    exp_q.push_back(mk(1'b1, x1, y1));
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    req0 = 1; req1 = 1;
    wait_gnt();
    if (gnt0) req0 = 0;
    if (gnt1) req1 = 0;
    wait_gnt();
    req0 = 0; req1 = 0;
    wait_idle();
  endtask

  initial begin
    int g1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out", out, 0);
    check("rst_cout", cout, 0);
    check("rst_pulses", {gnt0, gnt1, done0, done1}, 0);

    // single requester 0
    exp_q.push_back(mk(1'b0, 8'h5A, 8'h3C));
    a0 = 8'h5A; b0 = 8'h3C; req0 = 1;
    wait_gnt();
    req0 = 0;
    wait_idle();
    check("out_hold", out, 8'h96);

    // tie after reset: 0 first, then 1
    do_reset();
    tie(8'hFF, 8'h01, 8'h12, 8'h34);

    // both held for 4 ops
    gap_en = 1; have_prev = 0;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(i % 2 ? mk(1'b1, 8'hF0, 8'h20)
                            : mk(1'b0, 8'h10, 8'h20));
    a0 = 8'h10; b0 = 8'h20; a1 = 8'hF0; b1 = 8'h20;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) wait_gnt();
    req0 = 0; req1 = 0;
    wait_idle();
    gap_en = 0;

    // reset on 4th ADD cycle aborts silently
    exp_q.push_back(mk(1'b0, 8'h77, 8'h11));
    a0 = 8'h77; b0 = 8'h11; req0 = 1;
    wait_gnt();
    req0 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_out", out, 0);
    check("abort_cout", cout, 0);
    rst = 0;
    void'(exp_q.pop_front());
    repeat (12) @(negedge clk);
    tie(8'h80, 8'h80, 8'h01, 8'h02);

    // req1 pulse during ADD is ignored
    exp_q.push_back(mk(1'b0, 8'h33, 8'h44));
    a0 = 8'h33; b0 = 8'h44; req0 = 1;
    g1 = gnt1_cnt;
    wait_gnt();
    req0 = 0;
    repeat (2) @(negedge clk);
    req1 = 1;
    repeat (3) @(negedge clk);
    req1 = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("no_gnt1", gnt1_cnt - g1, 0);

    // operand change after grant has no effect
    exp_q.push_back(mk(1'b0, 8'h01, 8'h01));
    a0 = 8'h01; b0 = 8'h01; req0 = 1;
    wait_gnt();
    a0 = 8'hFF; req0 = 0;
    wait_idle();

    // random single-requester ops
    for (int i = 0; i < 6; i++) begin
      logic o;
      logic [7:0] x, y;
      o = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = 8'($urandom);
      exp_q.push_back(mk(o, x, y));
      if (o) begin a1 = x; b1 = y; req1 = 1; end
      else begin a0 = x; b0 = y; req0 = 1; end
      wait_gnt();
      req0 = 0; req1 = 0;
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
